// File: rtl/ddr3_local_pkg.sv
`default_nettype none
// ============================================================================
// ddr3_local_pkg
// Shared command codes, FSM state type and burst helpers for the DDR3 local
// interface responder.
// Revision: 1.0 - initial release
// ============================================================================
package ddr3_local_pkg;

   localparam logic [3:0] CMD_READ   = 4'b0001;
   localparam logic [3:0] CMD_WRITE  = 4'b0010;
   localparam logic [3:0] CMD_READA  = 4'b0011;
   localparam logic [3:0] CMD_WRITEA = 4'b0100;

   localparam int BEATS_PER_BURST = 2;

   typedef enum logic [2:0] {
      UNINIT  = 3'd0,
      INIT    = 3'd1,
      READY   = 3'd2,
      WR_DATA = 3'd3,
      RD_WAIT = 3'd4,
      RD_DATA = 3'd5
   } state_t;

   // Index of the final beat of a command; a burst count of 0 encodes 32.
   function automatic logic [5:0] last_beat(input logic [4:0] burst_cnt);
      logic [6:0] n;
      n = (burst_cnt == 5'd0) ? 7'd32 : {2'b00, burst_cnt};
      return 6'(n * BEATS_PER_BURST - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_local_responder_if.sv
`default_nettype none
// ============================================================================
// ddr3_local_responder_if
// DDR3 controller local user-interface signal bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface ddr3_local_responder_if;
   logic        init_start;
   logic        init_done;
   logic        cmd_valid;
   logic [3:0]  cmd;
   logic [4:0]  cmd_burst_cnt;
   logic [25:0] addr;
   logic        cmd_rdy;
   logic        datain_rdy;
   logic [63:0] write_data;
   logic [7:0]  data_mask;
   logic [63:0] read_data;
   logic        read_data_valid;
   logic        wl_err;

   modport master (
      output init_start, cmd_valid, cmd, cmd_burst_cnt, addr, write_data, data_mask,
      input  init_done, cmd_rdy, datain_rdy, read_data, read_data_valid, wl_err
   );

   modport slave (
      input  init_start, cmd_valid, cmd, cmd_burst_cnt, addr, write_data, data_mask,
      output init_done, cmd_rdy, datain_rdy, read_data, read_data_valid, wl_err
   );
endinterface
`default_nettype wire

// File: rtl/ddr3_resp_mem.sv
`default_nettype none
// ============================================================================
// ddr3_resp_mem
// Simple dual-port 2^ADDR_BITS x 64 RAM, registered read (1-cycle latency).
// Byte-enables exist only when DDR3_RESP_DATA_MASK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module ddr3_resp_mem #(
   parameter int ADDR_BITS = 10
) (
   input  wire logic                 clk,
   input  wire logic                 rstn,
   input  wire logic                 we,
   input  wire logic [ADDR_BITS-1:0] waddr,
   input  wire logic [63:0]          wdata,
`ifdef DDR3_RESP_DATA_MASK_EN
   input  wire logic [7:0]           wbe,
`endif
   input  wire logic                 re,
   input  wire logic [ADDR_BITS-1:0] raddr,
   output logic      [63:0]          rdata
);

   logic [63:0] r_mem [0:(1<<ADDR_BITS)-1];
   logic [63:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
`ifdef DDR3_RESP_DATA_MASK_EN
         for (int i = 0; i < 8; i++) begin
            if (wbe[i]) r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
`else
         r_mem[waddr] <= wdata;
`endif
      end
   end

   // Output register only advances on a read, so it holds between bursts.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)   r_rdata <= '0;
      else if (re) r_rdata <= r_mem[raddr];
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ddr3_local_responder.sv
`default_nettype none
// ============================================================================
// ddr3_local_responder
// Behavioural stand-in for the DDR3 controller local interface: init
// handshake, command acceptance, write-data pull and read return from BRAM.
// Optional byte masking: DDR3_RESP_DATA_MASK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ddr3_local_responder
   import ddr3_local_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int RD_LAT    = 4,
   parameter int INIT_DLY  = 16
) (
   input  wire logic              clk,
   input  wire logic              rstn,
   ddr3_local_responder_if.slave  bus
);

   state_t                 r_state;
   logic [15:0]            r_cnt;
   logic [5:0]             r_beat;
   logic [5:0]             r_last;
   logic [ADDR_BITS-1:0]   r_base;
   logic                   r_init_done;
   logic                   r_cmd_rdy;
   logic                   r_datain_rdy;
   logic                   r_rd_valid;

   logic                   w_accept;
   logic                   w_is_wr;
   logic                   w_is_rd;
   logic                   w_rd_en;
   logic [ADDR_BITS-1:0]   w_waddr;
   logic [ADDR_BITS-1:0]   w_raddr;
   logic [63:0]            w_rdata;

   // cmd_rdy is only ever high in READY, so it doubles as the accept qualifier.
   assign w_accept = r_cmd_rdy & bus.cmd_valid;
   assign w_is_wr  = (bus.cmd == CMD_WRITE) || (bus.cmd == CMD_WRITEA);
   assign w_is_rd  = (bus.cmd == CMD_READ)  || (bus.cmd == CMD_READA);
   assign w_waddr  = r_base + ADDR_BITS'(r_beat);

   // Reads run one beat ahead of read_data_valid to cover the RAM latency.
   assign w_rd_en  = ((r_state == RD_WAIT) && (r_cnt == 16'd0)) ||
                     ((r_state == RD_DATA) && (r_beat != r_last));
   assign w_raddr  = (r_state == RD_DATA) ? (w_waddr + ADDR_BITS'(1)) : r_base;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= UNINIT;
         r_cnt        <= '0;
         r_beat       <= '0;
         r_last       <= '0;
         r_base       <= '0;
         r_init_done  <= 1'b0;
         r_cmd_rdy    <= 1'b0;
         r_datain_rdy <= 1'b0;
         r_rd_valid   <= 1'b0;
      end else begin
         case (r_state)
            UNINIT: begin
               if (bus.init_start) begin
                  r_state     <= INIT;
                  r_cnt       <= 16'(INIT_DLY - 1);
                  r_init_done <= (INIT_DLY == 1);
               end
            end
            INIT: begin
               if (r_cnt == 16'd0) begin
                  r_init_done <= 1'b0;
                  r_cmd_rdy   <= 1'b1;
                  r_state     <= READY;
               end else begin
                  r_cnt       <= r_cnt - 16'd1;
                  r_init_done <= (r_cnt == 16'd1);
               end
            end
            READY: begin
               if (w_accept) begin
                  r_cmd_rdy <= 1'b0;
                  r_base    <= bus.addr[ADDR_BITS+1:2];
                  r_last    <= last_beat(bus.cmd_burst_cnt);
                  r_beat    <= '0;
                  if (w_is_wr) begin
                     r_state      <= WR_DATA;
                     r_datain_rdy <= 1'b1;
                  end else if (w_is_rd) begin
                     r_state <= RD_WAIT;
                     r_cnt   <= 16'(RD_LAT - 2);
                  end
               end else begin
                  r_cmd_rdy <= 1'b1;
               end
            end
            WR_DATA: begin
               if (r_beat == r_last) begin
                  r_datain_rdy <= 1'b0;
                  r_cmd_rdy    <= 1'b1;
                  r_state      <= READY;
               end else begin
                  r_beat <= r_beat + 6'd1;
               end
            end
            RD_WAIT: begin
               if (r_cnt == 16'd0) begin
                  r_state    <= RD_DATA;
                  r_rd_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            RD_DATA: begin
               if (r_beat == r_last) begin
                  r_rd_valid <= 1'b0;
                  r_cmd_rdy  <= 1'b1;
                  r_state    <= READY;
               end else begin
                  r_beat <= r_beat + 6'd1;
               end
            end
            default: r_state <= UNINIT;
         endcase
      end
   end

   ddr3_resp_mem #(
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .clk   (clk),
      .rstn  (rstn),
      .we    (r_datain_rdy),
      .waddr (w_waddr),
      .wdata (bus.write_data),
`ifdef DDR3_RESP_DATA_MASK_EN
      .wbe   (~bus.data_mask),
`endif
      .re    (w_rd_en),
      .raddr (w_raddr),
      .rdata (w_rdata)
   );

   assign bus.init_done       = r_init_done;
   assign bus.cmd_rdy         = r_cmd_rdy;
   assign bus.datain_rdy      = r_datain_rdy;
   assign bus.read_data       = w_rdata;
   assign bus.read_data_valid = r_rd_valid;
   assign bus.wl_err          = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_local_responder.sv
`default_nettype none
// ============================================================================
// tb_ddr3_local_responder
// Randomized self-checking bench against a word-array reference memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ddr3_local_responder;

   localparam int AB    = 10;
   localparam int RL    = 4;
   localparam int ID    = 16;
   localparam int DEPTH = 1 << AB;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   ddr3_local_responder_if bus ();

   ddr3_local_responder #(
      .ADDR_BITS (AB),
      .RD_LAT    (RL),
      .INIT_DLY  (ID)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] ref_mem [DEPTH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [25:0] mk_addr(input int word);
      logic [25:0] a;
      logic [9:0]  w;
      a       = 26'($urandom);
      w       = 10'(word);
      a[11:2] = w;
      return a;
   endfunction

   task automatic model_write(input int word, input logic [63:0] d, input logic [7:0] m);
`ifdef DDR3_RESP_DATA_MASK_EN
      for (int i = 0; i < 8; i++)
         if (!m[i]) ref_mem[word % DEPTH][8*i +: 8] = d[8*i +: 8];
`else
      if (m === 8'hxx) $display("mask undriven");
      ref_mem[word % DEPTH] = d;
`endif
   endtask

   task automatic wait_rdy();
      for (int i = 0; i < 300 && !bus.cmd_rdy; i++) tick();
      chk("cmd_rdy_wait", bus.cmd_rdy, 1);
   endtask

   task automatic do_init();
      bus.init_start = 1'b1;
      bus.cmd_valid  = 1'b1;
      bus.cmd        = 4'b0001;
      for (int c = 1; c <= ID + 1; c++) begin
         tick();
         if (c == 8) bus.cmd_valid = 1'b0;
         chk("init_done", bus.init_done, 64'(c == ID));
         chk("init_cmd_rdy", bus.cmd_rdy, 64'(c == ID + 1));
         chk("init_no_rdv", bus.read_data_valid, 0);
      end
      bus.init_start = 1'b0;
   endtask

   task automatic do_write(input int word, input int bc, input bit rnd,
                           input logic [63:0] val, input logic [63:0] step, input logic [7:0] mask);
      int          beats;
      logic [63:0] d;
      logic [7:0]  m;
      beats = 2 * ((bc == 0) ? 32 : bc);
      wait_rdy();
      bus.cmd_valid     = 1'b1;
      bus.cmd           = ($urandom_range(0, 1) == 1) ? 4'b0010 : 4'b0100;
      bus.cmd_burst_cnt = 5'(bc);
      bus.addr          = mk_addr(word);
      tick();
      for (int k = 0; k < beats; k++) begin
         chk("wr_datain_rdy", bus.datain_rdy, 1);
         chk("wr_cmd_rdy_low", bus.cmd_rdy, 0);
         d = rnd ? {$urandom, $urandom} : val + 64'(k) * step;
         m = rnd ? 8'($urandom) : mask;
         bus.write_data = d;
         bus.data_mask  = m;
         model_write(word + k, d, m);
         bus.cmd_valid = 1'($urandom_range(0, 1));
         bus.cmd       = 4'b0001;
         tick();
      end
      bus.cmd_valid = 1'b0;
      chk("wr_datain_end", bus.datain_rdy, 0);
      chk("wr_cmd_rdy_back", bus.cmd_rdy, 1);
   endtask

   // abort > 0: assert reset asynchronously in the abort-th valid beat.
   task automatic do_read(input int word, input int bc, input int abort);
      int beats;
      bit exp_v;
      beats = 2 * ((bc == 0) ? 32 : bc);
      wait_rdy();
      bus.cmd_valid     = 1'b1;
      bus.cmd           = ($urandom_range(0, 1) == 1) ? 4'b0001 : 4'b0011;
      bus.cmd_burst_cnt = 5'(bc);
      bus.addr          = mk_addr(word);
      tick();
      for (int c = 1; c <= RL + beats; c++) begin
         bus.cmd_valid = 1'($urandom_range(0, 1));
         bus.cmd       = 4'b0010;
         exp_v = (c >= RL) && (c <= RL + beats - 1);
         chk("rd_valid", bus.read_data_valid, 64'(exp_v));
         if (exp_v) chk("rd_data", bus.read_data, ref_mem[(word + c - RL) % DEPTH]);
         if (abort > 0 && c == RL + abort - 1) begin
            #2 rstn = 1'b0;
            #1;
            bus.cmd_valid = 1'b0;
            chk("rst_rd_valid", bus.read_data_valid, 0);
            chk("rst_cmd_rdy", bus.cmd_rdy, 0);
            chk("rst_read_data", bus.read_data, 0);
            chk("rst_datain_rdy", bus.datain_rdy, 0);
            return;
         end
         if (c == RL + beats) begin
            bus.cmd_valid = 1'b0;
            chk("rd_cmd_rdy_back", bus.cmd_rdy, 1);
            chk("rd_data_hold", bus.read_data, ref_mem[(word + beats - 1) % DEPTH]);
         end else begin
            chk("rd_cmd_rdy_low", bus.cmd_rdy, 0);
            tick();
         end
      end
   endtask

   task automatic do_drop(input logic [3:0] code);
      wait_rdy();
      bus.cmd_valid = 1'b1;
      bus.cmd       = code;
      bus.addr      = mk_addr(0);
      tick();
      bus.cmd_valid = 1'b0;
      chk("drop_cmd_rdy_low", bus.cmd_rdy, 0);
      tick();
      chk("drop_cmd_rdy_back", bus.cmd_rdy, 1);
      chk("drop_no_datain", bus.datain_rdy, 0);
      chk("drop_no_rdv", bus.read_data_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn              = 1'b0;
      bus.init_start    = 1'b0;
      bus.cmd_valid     = 1'b0;
      bus.cmd           = 4'b0000;
      bus.cmd_burst_cnt = 5'd0;
      bus.addr          = '0;
      bus.write_data    = '0;
      bus.data_mask     = '0;
      repeat (3) tick();
      chk("rst_init_done", bus.init_done, 0);
      chk("rst_cmd_rdy", bus.cmd_rdy, 0);
      chk("rst_datain_rdy", bus.datain_rdy, 0);
      chk("rst_rd_valid", bus.read_data_valid, 0);
      chk("rst_wl_err", bus.wl_err, 0);
      chk("rst_read_data", bus.read_data, 0);

      rstn = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd       = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("uninit_cmd_rdy", bus.cmd_rdy, 0);
         chk("uninit_datain", bus.datain_rdy, 0);
      end
      do_init();

      // Fill the whole RAM so every later read has a known expectation.
      for (int b = 0; b < DEPTH / 64; b++)
         do_write(b * 64, 0, 1'b0, 64'hC0DE_0000_0000_0000 + 64'(b * 64), 64'd1, 8'h00);
      do_read(128, 0, 0);

      do_write(16, 1, 1'b0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 8'h00);
      do_read(16, 1, 0);

      do_write(1023, 1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd1, 8'h00);
      do_read(0, 1, 0);
      do_read(1023, 1, 0);
      do_read(1000, 0, 0);

      do_write(300, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'h00);
      do_write(300, 1, 1'b0, 64'h0, 64'd0, 8'h0F);
      do_read(300, 1, 0);

      do_drop(4'b0000);
      do_drop(4'b0101);
      do_drop(4'b1111);

      for (int t = 0; t < 40; t++) begin
         int word;
         int bc;
         word = int'($urandom_range(0, DEPTH - 1));
         bc   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
         if ($urandom_range(0, 1) == 1) do_write(word, bc, 1'b1, 64'd0, 64'd0, 8'h00);
         else                           do_read(word, bc, 0);
      end

      do_write(500, 2, 1'b1, 64'd0, 64'd0, 8'h00);
      do_read(500, 2, 3);
      repeat (3) tick();
      chk("rst_hold_cmd_rdy", bus.cmd_rdy, 0);
      rstn = 1'b1;
      tick();
      do_init();
      do_read(500, 2, 0);
      do_read(16, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
